// File: rtl/encoder.sv
// One-hot to binary encoder with error flag and saturating error count; 1-cycle latency, 2-entry output queue.
// din_rdy is registered (low only when the queue is full) so downstream stalls never drop data or form a ready path.

module encoder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Ready is registered from the next count, so it never depends on out_rdy in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_rdy <= 1'b1;
        end else begin
            cnt    <= cnt_nxt;
            in_rdy <= (cnt_nxt < CW'(DEPTH));
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end

    assign out_vld = (cnt != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
endmodule

module encoder #(
    parameter int DIN_WIDTH    = 16,
    parameter int DOUT_WIDTH   = $clog2(DIN_WIDTH),
    parameter bit PRIORITY_LSB = 1'b1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_v,
    output logic                  din_rdy,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_err,
    output logic                  dout_v,
    input  logic                  dout_rdy,
    input  logic                  clr_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);
    typedef struct packed {
        logic [DOUT_WIDTH-1:0] idx;
        logic                  err;
    } res_t;

    res_t enc_res;
    res_t head_res;
    logic zero_hot;
    logic multi_hot;
    logic push;

    assign zero_hot  = (din == '0);
    assign multi_hot = |(din & (din - DIN_WIDTH'(1)));

    // The scan direction decides which set bit wins on multi-hot input: the last match overwrites.
    always_comb begin
        enc_res.idx = '0;
        enc_res.err = zero_hot | multi_hot;
        if (PRIORITY_LSB) begin
            for (int i = DIN_WIDTH - 1; i >= 0; i--) begin
                if (din[i]) enc_res.idx = DOUT_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < DIN_WIDTH; i++) begin
                if (din[i]) enc_res.idx = DOUT_WIDTH'(i);
            end
        end
    end

    encoder_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (2)
    ) u_q (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (din_v),
        .in_rdy  (din_rdy),
        .in_dat  (enc_res),
        .out_vld (dout_v),
        .out_rdy (dout_rdy),
        .out_dat (head_res)
    );

    assign dout     = head_res.idx;
    assign dout_err = head_res.err;
    assign push     = din_v & din_rdy;

    // Clear takes precedence over a coincident erroring push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (push && enc_res.err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_encoder.sv
// Bench for encoder: one LSB-priority and one MSB-priority instance share all inputs; a negedge monitor scores both.
module tb_encoder;
    typedef struct {
        int lsb;
        int msb;
        bit err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_v;
    logic        dout_rdy;
    logic        clr_cnt;

    logic        din_rdy_l, din_rdy_m;
    logic [3:0]  dout_l, dout_m;
    logic        dout_err_l, dout_err_m;
    logic        dout_v_l, dout_v_m;
    logic [3:0]  err_cnt_l, err_cnt_m;

    int   total  = 0;
    int   passed = 0;
    int   mcnt   = 0;
    int   merr   = 0;
    bit   push_m;
    bit   pop_m;
    exp_t cur_exp;
    exp_t sb[$];

    encoder #(.DIN_WIDTH(16), .PRIORITY_LSB(1'b1), .CNT_WIDTH(4)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_v(din_v), .din_rdy(din_rdy_l),
        .dout(dout_l), .dout_err(dout_err_l), .dout_v(dout_v_l), .dout_rdy(dout_rdy),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt_l)
    );

    encoder #(.DIN_WIDTH(16), .PRIORITY_LSB(1'b0), .CNT_WIDTH(4)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_v(din_v), .din_rdy(din_rdy_m),
        .dout(dout_m), .dout_err(dout_err_m), .dout_v(dout_v_m), .dout_rdy(dout_rdy),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input int l, input int m, input bit e);
        exp_t r;
        r.lsb = l;
        r.msb = m;
        r.err = e;
        return r;
    endfunction

    // Scoreboard monitor: checks outputs against the model queue, then predicts the upcoming edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            mcnt = 0;
            merr = 0;
            chk("rst_dout_v", dout_v_l, 0);
            chk("rst_din_rdy", din_rdy_l, 1);
            chk("rst_err_cnt", err_cnt_l, 0);
            chk("rst_dout", dout_l, 0);
        end else begin
            chk("din_rdy_l", din_rdy_l, (mcnt < 2) ? 1 : 0);
            chk("din_rdy_m", din_rdy_m, (mcnt < 2) ? 1 : 0);
            chk("dout_v_l", dout_v_l, (mcnt != 0) ? 1 : 0);
            chk("dout_v_m", dout_v_m, (mcnt != 0) ? 1 : 0);
            chk("err_cnt_l", err_cnt_l, merr);
            chk("err_cnt_m", err_cnt_m, merr);
            if (mcnt != 0 && sb.size() != 0) begin
                chk("head_dout_l", dout_l, sb[0].lsb);
                chk("head_dout_m", dout_m, sb[0].msb);
                chk("head_err_l", dout_err_l, sb[0].err);
                chk("head_err_m", dout_err_m, sb[0].err);
            end else begin
                chk("idle_dout_l", dout_l, 0);
                chk("idle_err_l", dout_err_l, 0);
                chk("idle_dout_m", dout_m, 0);
            end
            push_m = din_v && (mcnt < 2);
            pop_m  = dout_rdy && (mcnt != 0);
            if (pop_m && sb.size() != 0) void'(sb.pop_front());
            if (push_m) sb.push_back(cur_exp);
            mcnt = mcnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
            if (clr_cnt) merr = 0;
            else if (push_m && cur_exp.err && merr < 15) merr++;
        end
    end

    task automatic send(input logic [15:0] d, input exp_t e);
        int n;
        n = 0;
        din     = d;
        din_v   = 1'b1;
        cur_exp = e;
        @(negedge clk);
        while (!din_rdy_l && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        din_v = 1'b0;
        din   = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mcnt != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        din      = '0;
        din_v    = 1'b0;
        dout_rdy = 1'b1;
        clr_cnt  = 1'b0;
        cur_exp  = mk(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) send(16'h0001 << i, mk(i, i, 1'b0));
        drain();
        chk("sweep_err_cnt", err_cnt_l, 0);

        send(16'h0000, mk(0, 0, 1'b1));
        send(16'h0110, mk(4, 8, 1'b1));
        drain();
        chk("bad_err_cnt_l", err_cnt_l, 2);
        chk("bad_err_cnt_m", err_cnt_m, 2);

        dout_rdy = 1'b0;
        send(16'h0002, mk(1, 1, 1'b0));
        send(16'h0008, mk(3, 3, 1'b0));
        chk("bp_din_rdy_low", din_rdy_l, 0);
        fork
            send(16'h0020, mk(5, 5, 1'b0));
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_held_dout", dout_l, 1);
                dout_rdy = 1'b1;
            end
        join
        drain();

        fork
            for (int i = 0; i < 16; i++) send(16'h0001 << ((i * 7) % 16), mk((i * 7) % 16, (i * 7) % 16, 1'b0));
            for (int k = 0; k < 60; k++) begin
                @(posedge clk);
                #1;
                dout_rdy = ~dout_rdy;
            end
        join
        dout_rdy = 1'b1;
        drain();

        for (int i = 0; i < 20; i++) send(16'h0000, mk(0, 0, 1'b1));
        drain();
        chk("sat_err_cnt_l", err_cnt_l, 15);
        chk("sat_err_cnt_m", err_cnt_m, 15);

        clr_cnt = 1'b1;
        send(16'h0000, mk(0, 0, 1'b1));
        clr_cnt = 1'b0;
        chk("clr_wins", err_cnt_l, 0);
        send(16'h0000, mk(0, 0, 1'b1));
        chk("count_after_clr", err_cnt_l, 1);
        drain();

        dout_rdy = 1'b0;
        send(16'h0001, mk(0, 0, 1'b0));
        send(16'h0004, mk(2, 2, 1'b0));
        din   = 16'hffff;
        din_v = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_dout_v", dout_v_l, 0);
        chk("arst_din_rdy", din_rdy_l, 1);
        chk("arst_err_cnt", err_cnt_l, 0);
        chk("arst_dout", dout_l, 0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        dout_rdy = 1'b1;
        send(16'h8000, mk(15, 15, 1'b0));
        chk("post_rst_v", dout_v_l, 1);
        chk("post_rst_dout", dout_l, 15);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
